// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD registered read ports, one write port, an automatic
// post-reset clear sequence gated by ready, optional hardwired x0 and optional write bypass.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_discard;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    assign wr_discard = ZERO_REG && (wr_addr == '0);

    // The clear sequence owns the single write port while in StInit.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (&clr_ptr_q) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end
            end
            StRun: begin
                mem_we = wr_en && !wr_discard;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StInit;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
        end
    end

    // Storage is not reset directly; the clear sequence zeroes it before ready rises.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] data_q;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        // Zero register wins over bypass, so a discarded x0 write never leaks out.
        always_comb begin
            if (ZERO_REG && (addr == '0)) begin
                val = '0;
            end else if (BYPASS && wr_en && (wr_addr == addr)) begin
                val = wr_data;
            end else begin
                val = mem_q[addr];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
            end else if ((state_q == StRun) && rd_en[i]) begin
                data_q <= val;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data_q;
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default instance, a no-bypass/no-zero-reg instance and a
// three-port 16-entry instance, all sharing one clock and reset.
module tb_regfile_param;

    logic        clk;
    logic        reset;

    logic [1:0]  rd_en_ab;
    logic [9:0]  rd_addr_ab;
    logic        wr_en_ab;
    logic [4:0]  wr_addr_ab;
    logic [31:0] wr_data_ab;
    logic [63:0] rd_data_a, rd_data_b;
    logic        ready_a, ready_b;

    logic [2:0]  rd_en_c;
    logic [11:0] rd_addr_c;
    logic        wr_en_c;
    logic [3:0]  wr_addr_c;
    logic [31:0] wr_data_c;
    logic [95:0] rd_data_c;
    logic        ready_c;

    int checks   = 0;
    int failures = 0;

    regfile_param dut_a (
        .clk(clk), .reset(reset), .rd_en(rd_en_ab), .rd_addr(rd_addr_ab), .rd_data(rd_data_a),
        .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab), .ready(ready_a)
    );

    regfile_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rd_en(rd_en_ab), .rd_addr(rd_addr_ab), .rd_data(rd_data_b),
        .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab), .ready(ready_b)
    );

    regfile_param #(.ADDR_W(4), .NUM_RD(3)) dut_c (
        .clk(clk), .reset(reset), .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .ready(ready_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        rd_en_ab   = '0;
        rd_addr_ab = '0;
        wr_en_ab   = 1'b0;
        wr_addr_ab = '0;
        wr_data_ab = '0;
        rd_en_c    = '0;
        rd_addr_c  = '0;
        wr_en_c    = 1'b0;
        wr_addr_c  = '0;
        wr_data_c  = '0;

        // Reset for two edges
        tick();
        tick();
        check("reset_ready_a", 96'(ready_a), 96'(0));
        check("reset_ready_c", 96'(ready_c), 96'(0));
        check("reset_rd_a", 96'(rd_data_a), 96'(0));
        check("reset_rd_c", rd_data_c, 96'(0));

        // Initial clear; write/read traffic during INIT must be ignored
        reset      = 1'b0;
        wr_en_ab   = 1'b1;
        wr_addr_ab = 5'd9;
        wr_data_ab = 32'hFFFF_FFFF;
        rd_en_ab   = 2'b11;
        rd_addr_ab = {5'd9, 5'd9};
        for (int e = 1; e <= 32; e++) begin
            tick();
            check("init_ready_a", 96'(ready_a), 96'(e >= 32));
            check("init_ready_b", 96'(ready_b), 96'(e >= 32));
            check("init_ready_c", 96'(ready_c), 96'(e >= 16));
            check("init_rd_a", 96'(rd_data_a), 96'(0));
        end
        wr_en_ab = 1'b0;

        // All registers read zero after the clear
        for (int a = 0; a < 32; a++) begin
            rd_addr_ab = {5'(a), 5'(a)};
            tick();
            check("clear_rd_a", 96'(rd_data_a), 96'(0));
            check("clear_rd_b", 96'(rd_data_b), 96'(0));
        end

        // Write then read with latency 1
        rd_en_ab   = 2'b00;
        wr_en_ab   = 1'b1;
        wr_addr_ab = 5'd5;
        wr_data_ab = 32'hDEAD_BEEF;
        tick();
        wr_en_ab   = 1'b0;
        rd_en_ab   = 2'b01;
        rd_addr_ab = {5'd0, 5'd5};
        tick();
        check("wr_rd_x5_a", 96'(rd_data_a), 96'({32'h0, 32'hDEAD_BEEF}));
        check("wr_rd_x5_b", 96'(rd_data_b), 96'({32'h0, 32'hDEAD_BEEF}));

        // Same-cycle write and dual read of x7
        wr_en_ab   = 1'b1;
        wr_addr_ab = 5'd7;
        wr_data_ab = 32'h1234_5678;
        rd_en_ab   = 2'b11;
        rd_addr_ab = {5'd7, 5'd7};
        tick();
        check("bypass_x7_a", 96'(rd_data_a), 96'({32'h1234_5678, 32'h1234_5678}));
        check("nobypass_x7_b", 96'(rd_data_b), 96'(0));
        wr_en_ab = 1'b0;
        tick();
        check("after_x7_b", 96'(rd_data_b), 96'({32'h1234_5678, 32'h1234_5678}));

        // x0 write with same-cycle read, then plain read
        wr_en_ab   = 1'b1;
        wr_addr_ab = 5'd0;
        wr_data_ab = 32'hFFFF_FFFF;
        rd_addr_ab = {5'd0, 5'd0};
        tick();
        check("x0_bypass_a", 96'(rd_data_a), 96'(0));
        check("x0_nobypass_b", 96'(rd_data_b), 96'(0));
        wr_en_ab = 1'b0;
        tick();
        check("x0_read_a", 96'(rd_data_a), 96'(0));
        check("x0_read_b", 96'(rd_data_b), 96'({32'hFFFF_FFFF, 32'hFFFF_FFFF}));

        // Disabled port holds its value across a rewrite of its register
        wr_en_ab   = 1'b1;
        wr_addr_ab = 5'd3;
        wr_data_ab = 32'hA5A5_A5A5;
        rd_en_ab   = 2'b00;
        tick();
        wr_en_ab   = 1'b0;
        rd_en_ab   = 2'b10;
        rd_addr_ab = {5'd3, 5'd0};
        tick();
        check("x3_read_a", 96'(rd_data_a), 96'({32'hA5A5_A5A5, 32'h0}));
        check("x3_read_b", 96'(rd_data_b), 96'({32'hA5A5_A5A5, 32'hFFFF_FFFF}));
        rd_en_ab   = 2'b00;
        wr_en_ab   = 1'b1;
        wr_data_ab = 32'h5A5A_5A5A;
        tick();
        wr_en_ab = 1'b0;
        tick();
        check("hold_port1_a", 96'(rd_data_a), 96'({32'hA5A5_A5A5, 32'h0}));
        check("hold_port1_b", 96'(rd_data_b), 96'({32'hA5A5_A5A5, 32'hFFFF_FFFF}));
        rd_en_ab = 2'b10;
        tick();
        check("x3_new_a", 96'(rd_data_a), 96'({32'h5A5A_5A5A, 32'h0}));

        // Three-port instance: write/read, then mixed bypass across ports
        rd_en_ab  = 2'b00;
        wr_en_c   = 1'b1;
        wr_addr_c = 4'd5;
        wr_data_c = 32'hCAFE_F00D;
        tick();
        wr_en_c   = 1'b0;
        rd_en_c   = 3'b111;
        rd_addr_c = {4'd5, 4'd5, 4'd5};
        tick();
        check("c_x5_all", rd_data_c, {32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D});
        wr_en_c   = 1'b1;
        wr_addr_c = 4'd2;
        wr_data_c = 32'h0BAD_CAFE;
        rd_addr_c = {4'd2, 4'd5, 4'd2};
        tick();
        check("c_mixed", rd_data_c, {32'h0BAD_CAFE, 32'hCAFE_F00D, 32'h0BAD_CAFE});

        // Mid-RUN reset pulse with a write that must be dropped
        reset      = 1'b1;
        wr_en_ab   = 1'b1;
        wr_addr_ab = 5'd5;
        wr_data_ab = 32'h7777_7777;
        rd_en_ab   = 2'b11;
        rd_addr_ab = {5'd5, 5'd5};
        wr_addr_c  = 4'd5;
        wr_data_c  = 32'h7777_7777;
        rd_addr_c  = {4'd5, 4'd5, 4'd5};
        tick();
        check("rst2_ready_a", 96'(ready_a), 96'(0));
        check("rst2_ready_c", 96'(ready_c), 96'(0));
        check("rst2_rd_a", 96'(rd_data_a), 96'(0));
        check("rst2_rd_c", rd_data_c, 96'(0));
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            check("reinit_ready_a", 96'(ready_a), 96'(e >= 32));
            check("reinit_ready_c", 96'(ready_c), 96'(e >= 16));
            check("reinit_rd_a", 96'(rd_data_a), 96'(0));
            check("reinit_rd_c", rd_data_c, 96'(0));
            if (e == 16) begin
                wr_en_c = 1'b0;
                rd_en_c = 3'b000;
            end
        end
        wr_en_ab = 1'b0;
        rd_en_c  = 3'b111;
        tick();
        check("reinit_x5_a", 96'(rd_data_a), 96'(0));
        check("reinit_x5_b", 96'(rd_data_b), 96'(0));
        check("reinit_x5_c", rd_data_c, 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
